// File: rtl/systolic_ctrl_if.sv
// Readout handshake between the systolic sequencer and the accumulator row consumer.
// Ports: row_sel (row presented), rd_valid (row valid), rd_ready (consumer accepts).
// master = sequencer side, slave = consumer side.
interface systolic_ctrl_if #(
   parameter int N = 8
);
   localparam int RS_W = (N > 1) ? $clog2(N) : 1;

   logic [RS_W-1:0] row_sel;
   logic            rd_valid;
   logic            rd_ready;

   modport master (output row_sel, output rd_valid, input rd_ready);
   modport slave  (input row_sel, input rd_valid, output rd_ready);
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an NxN systolic array: clear, skewed feed of K steps, drain, row readout.
// Latency: 1 + (K+N-1) + (N-1) + N + 1 cycles from start accept to end of DONE (K=0 skips feed/drain).
// Backpressure: READ holds row_sel/rd_valid while rd_ready=0; start outside IDLE is dropped.
// Ports: clk/rst (sync, active-high); start/k_len job command; busy/done status;
//   array_clr/array_en/feed_cnt/lane_vld drive the array and operand buffers; rd = readout handshake.
// Optional: SYSTOLIC_CTRL_PERF_EN adds a 32-bit perf_cycles job-length counter output.
module systolic_ctrl #(
   parameter int N     = 8,
   parameter int K_W   = 8,
   parameter int CNT_W = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [K_W-1:0]   k_len,
   output logic             busy,
   output logic             done,
   output logic             array_clr,
   output logic             array_en,
   output logic [CNT_W-1:0] feed_cnt,
   output logic [N-1:0]     lane_vld,
`ifdef SYSTOLIC_CTRL_PERF_EN
   output logic [31:0]      perf_cycles,
`endif
   systolic_ctrl_if.master  rd
);
   localparam int RS_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {
      IDLE, CLEAR, FEED, DRAIN, READ, DONE
   } state_t;

   state_t           state, state_nxt;
   logic [K_W-1:0]   k_q;
   logic [CNT_W-1:0] t_q;
   logic [RS_W-1:0]  dcnt;
   logic [RS_W-1:0]  rsel;
   logic [CNT_W-1:0] t_last;
   logic             feed_last, drain_last, row_last, rd_fire;

   // Last feed step is t = K+N-2: lane N-1 carries its final operand then.
   assign t_last     = CNT_W'(k_q) + CNT_W'(N - 2);
   assign feed_last  = (t_q == t_last);
   assign drain_last = (dcnt == RS_W'(N - 2));
   assign row_last   = (rsel == RS_W'(N - 1));
   assign rd_fire    = (state == READ) && rd.rd_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      busy        = (state != IDLE);
      done        = (state == DONE);
      array_clr   = (state == CLEAR);
      array_en    = (state == FEED) || (state == DRAIN);
      feed_cnt    = t_q;
      rd.rd_valid = (state == READ);
      rd.row_sel  = rsel;
      lane_vld    = '0;
      // Lane i is skewed by i steps and carries real data for K steps.
      if (state == FEED) begin
         for (int i = 0; i < N; i++) begin
            lane_vld[i] = (t_q >= CNT_W'(i)) && ((t_q - CNT_W'(i)) < CNT_W'(k_q));
         end
      end
      case (state)
         IDLE:    if (start) state_nxt = CLEAR;
         CLEAR:   state_nxt = (k_q == '0) ? READ : FEED;
         FEED:    if (feed_last) state_nxt = DRAIN;
         DRAIN:   if (drain_last) state_nxt = READ;
         READ:    if (rd_fire && row_last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_q  <= '0;
         t_q  <= '0;
         dcnt <= '0;
         rsel <= '0;
      end else begin
         case (state)
            IDLE:  if (start) k_q <= k_len;
            CLEAR: begin
               t_q  <= '0;
               dcnt <= '0;
               rsel <= '0;
            end
            // t stops at its final value so it holds through DRAIN.
            FEED:  if (!feed_last) t_q <= t_q + 1'b1;
            DRAIN: if (!drain_last) dcnt <= dcnt + 1'b1;
            READ:  if (rd_fire) rsel <= row_last ? '0 : rsel + 1'b1;
            DONE:  t_q <= '0;
            default: ;
         endcase
      end
   end

`ifdef SYSTOLIC_CTRL_PERF_EN
   // The accept cycle is counted as the first cycle of the job, then every busy cycle.
   always_ff @(posedge clk) begin
      if (rst)                        perf_cycles <= '0;
      else if (state == IDLE && start) perf_cycles <= 32'd1;
      else if (state != IDLE)         perf_cycles <= perf_cycles + 32'd1;
   end
`endif
endmodule
